// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz timing constants shared by the sync generator and the text generator.
package vga_timing_pkg;
  localparam int COORD_W = 10;
  localparam int VGA_TICK_DIV = 4;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BACK = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BACK = 33;
  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  typedef logic [COORD_W-1:0] coord_t;
  function automatic logic in_span(coord_t c, coord_t lo, coord_t hi);
    return c >= lo && c <= hi;
  endfunction
endpackage

// File: rtl/vga_tick_div.sv
// vga_tick_div: free-running divider emitting a registered one-clk p_tick every DIV clocks.
module vga_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] ONE = W'(1);
  logic [W-1:0] div_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div_cnt <= '0;
      p_tick <= 1'b0;
    end else begin
      div_cnt <= div_cnt == LAST ? '0 : div_cnt + ONE;
      p_tick <= div_cnt == LAST;
    end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel/line counters with registered hsync/vsync and frame_start.
// Define VGA_SYNC_PIPE_ALIGN_EN to delay hsync/vsync/video_on one pixel and expose video_on_raw.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int TICK_DIV  = VGA_TICK_DIV,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic   clk,
  input  logic   reset,
  output logic   p_tick,
  output coord_t pixel_x,
  output coord_t pixel_y,
  output logic   video_on,
  output logic   hsync,
  output logic   vsync,
  output logic   frame_start
`ifdef VGA_SYNC_PIPE_ALIGN_EN
  ,
  output logic   video_on_raw
`endif
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS = coord_t'(V_DISPLAY);
  localparam coord_t HS_LO = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_HI = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_LO = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_HI = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam coord_t ONE = coord_t'(1);
  coord_t h_nxt, v_nxt;
  logic h_end, v_end, hs_r, vs_r, vo_raw;
  vga_tick_div #(.DIV(TICK_DIV)) u_div (
    .clk(clk),
    .reset(reset),
    .p_tick(p_tick)
  );
  always_comb begin
    h_end = pixel_x == H_LAST;
    v_end = pixel_y == V_LAST;
    h_nxt = p_tick ? (h_end ? '0 : pixel_x + ONE) : pixel_x;
    v_nxt = p_tick && h_end ? (v_end ? '0 : pixel_y + ONE) : pixel_y;
    vo_raw = pixel_x < H_VIS && pixel_y < V_VIS;
  end
  // Syncs decode the next counts so they switch on the same edge as the counters.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
      hs_r <= 1'b1;
      vs_r <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pixel_x <= h_nxt;
      pixel_y <= v_nxt;
      hs_r <= !in_span(h_nxt, HS_LO, HS_HI);
      vs_r <= !in_span(v_nxt, VS_LO, VS_HI);
      frame_start <= p_tick && h_end && v_end;
    end
`ifdef VGA_SYNC_PIPE_ALIGN_EN
  // One pixel of lag to line up with a downstream stage that registers rgb from the counts.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      video_on <= 1'b1;
    end else if (p_tick) begin
      hsync <= hs_r;
      vsync <= vs_r;
      video_on <= vo_raw;
    end
  assign video_on_raw = vo_raw;
`else
  assign hsync = hs_r;
  assign vsync = vs_r;
  assign video_on = vo_raw;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks a default-timing and a shrunken-timing vga_sync_gen against an arithmetic model.
module tb_vga_sync_gen;
  typedef struct packed {
    logic pt;
    logic [9:0] x;
    logic [9:0] y;
    logic vo, hs, vs, fs;
  } obs_t;
  typedef struct {
    int s, k, x, y, vo, hs, vs, fs;
  } rec_t;
  localparam int TD[2] = '{4, 3};
  localparam int HD[2] = '{640, 8};
  localparam int HF[2] = '{16, 2};
  localparam int HS[2] = '{96, 3};
  localparam int HB[2] = '{48, 3};
  localparam int VD[2] = '{480, 6};
  localparam int VF[2] = '{10, 2};
  localparam int VS[2] = '{2, 2};
  localparam int VB[2] = '{33, 2};
`ifdef VGA_SYNC_PIPE_ALIGN_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam obs_t RST = '{pt: 1'b0, x: 10'd0, y: 10'd0, vo: 1'b1, hs: 1'b1, vs: 1'b1, fs: 1'b0};
  logic clk = 1'b0, reset = 1'b0;
  logic pt0, pt1, vo0, vo1, hs0, hs1, vs0, vs1, fs0, fs1;
  logic [9:0] x0, y0, x1, y1;
  obs_t g0, g1;
  int n = 0, checks = 0, errors = 0;
  bit chk_en = 1'b0;
  rec_t tbl[24];
`ifdef VGA_SYNC_PIPE_ALIGN_EN
  logic vr0, vr1;
`endif
  vga_sync_gen dut0 (
    .clk(clk), .reset(reset), .p_tick(pt0), .pixel_x(x0), .pixel_y(y0),
    .video_on(vo0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
`ifdef VGA_SYNC_PIPE_ALIGN_EN
    , .video_on_raw(vr0)
`endif
  );
  vga_sync_gen #(
    .TICK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut1 (
    .clk(clk), .reset(reset), .p_tick(pt1), .pixel_x(x1), .pixel_y(y1),
    .video_on(vo1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
`ifdef VGA_SYNC_PIPE_ALIGN_EN
    , .video_on_raw(vr1)
`endif
  );
  assign g0 = {pt0, x0, y0, vo0, hs0, vs0, fs0};
  assign g1 = {pt1, x1, y1, vo1, hs1, vs1, fs1};
  always #5 clk = ~clk;
  always @(posedge clk or negedge reset)
    if (!reset) n <= 0;
    else n <= n + 1;
  function automatic bit in_r(int v, int lo, int len);
    return v >= lo && v < lo + len;
  endfunction
  // Position in ticks since release: counts advance on the edge after each p_tick.
  function automatic int pos_of(int nn, int s);
    int k = nn > 0 ? (nn - 1) / TD[s] : 0;
    return k % ((HD[s] + HF[s] + HS[s] + HB[s]) * (VD[s] + VF[s] + VS[s] + VB[s]));
  endfunction
  function automatic obs_t model(int nn, int s);
    int ht = HD[s] + HF[s] + HS[s] + HB[s];
    int ft = ht * (VD[s] + VF[s] + VS[s] + VB[s]);
    int k = nn > 0 ? (nn - 1) / TD[s] : 0;
    int p = k % ft;
    int q = (PIPE != 0 && k > 0) ? (k - 1) % ft : p;
    obs_t o;
    o.pt = nn > 0 && nn % TD[s] == 0;
    o.x = 10'(p % ht);
    o.y = 10'(p / ht);
    o.fs = k > 0 && p == 0 && (nn - 1) % TD[s] == 0;
    o.vo = (q % ht) < HD[s] && (q / ht) < VD[s];
    o.hs = !in_r(q % ht, HD[s] + HF[s], HS[s]);
    o.vs = !in_r(q / ht, VD[s] + VF[s], VS[s]);
    return o;
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic chk_obs(string nm, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d: got pt=%b x=%0d y=%0d vo=%b hs=%b vs=%b fs=%b expected pt=%b x=%0d y=%0d vo=%b hs=%b vs=%b fs=%b",
               nm, n, act.pt, act.x, act.y, act.vo, act.hs, act.vs, act.fs,
               exp.pt, exp.x, exp.y, exp.vo, exp.hs, exp.vs, exp.fs);
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      chk_obs("cycle_dflt", g0, model(n, 0));
      chk_obs("cycle_small", g1, model(n, 1));
`ifdef VGA_SYNC_PIPE_ALIGN_EN
      chk("raw_dflt", int'(vr0), int'((pos_of(n, 0) % 800) < 640 && (pos_of(n, 0) / 800) < 480));
      chk("raw_small", int'(vr1), int'((pos_of(n, 1) % 16) < 8 && (pos_of(n, 1) / 16) < 6));
`endif
    end
  // Asynchronous reset between clock edges; outputs must drop before any edge arrives.
  task automatic do_reset(int hold);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_obs("rst_imm_dflt", g0, RST);
    chk_obs("rst_imm_small", g1, RST);
    repeat (hold) @(negedge clk);
    #1 reset = 1'b1;
  endtask
  initial begin
    int c, v, w, off;
    tbl[0]  = '{0, 0, 0, 0, 1, 1, 1, 0};
    tbl[1]  = '{0, 639, 639, 0, 1, 1, 1, 0};
    tbl[2]  = '{0, 640, 640, 0, 0, 1, 1, 0};
    tbl[3]  = '{0, 655, 655, 0, 0, 1, 1, 0};
    tbl[4]  = '{0, 656, 656, 0, 0, 0, 1, 0};
    tbl[5]  = '{0, 751, 751, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 752, 752, 0, 0, 1, 1, 0};
    tbl[7]  = '{0, 800, 0, 1, 1, 1, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, 1, 1, 1, 0};
    tbl[9]  = '{1, 7, 7, 0, 1, 1, 1, 0};
    tbl[10] = '{1, 8, 8, 0, 0, 1, 1, 0};
    tbl[11] = '{1, 10, 10, 0, 0, 0, 1, 0};
    tbl[12] = '{1, 12, 12, 0, 0, 0, 1, 0};
    tbl[13] = '{1, 13, 13, 0, 0, 1, 1, 0};
    tbl[14] = '{1, 16, 0, 1, 1, 1, 1, 0};
    tbl[15] = '{1, 87, 7, 5, 1, 1, 1, 0};
    tbl[16] = '{1, 88, 8, 5, 0, 1, 1, 0};
    tbl[17] = '{1, 96, 0, 6, 0, 1, 1, 0};
    tbl[18] = '{1, 128, 0, 8, 0, 1, 0, 0};
    tbl[19] = '{1, 138, 10, 8, 0, 0, 0, 0};
    tbl[20] = '{1, 159, 15, 9, 0, 1, 0, 0};
    tbl[21] = '{1, 160, 0, 10, 0, 1, 1, 0};
    tbl[22] = '{1, 191, 15, 11, 0, 1, 1, 0};
    tbl[23] = '{1, 192, 0, 0, 1, 1, 1, 1};
    #102 reset = 1'b1;
    #1 chk_obs("release_dflt", g0, RST);
    chk_obs("release_small", g1, RST);
    chk_en = 1'b1;
    c = 0;
    while (!pt0 && c < 20) begin @(negedge clk); c++; end
    chk("first_tick_clks", c, 4);
    c = 0;
    do begin @(negedge clk); c++; end while (!pt0 && c < 20);
    chk("tick_period_clks", c, 4);
    do_reset(2);
`ifdef VGA_SYNC_PIPE_ALIGN_EN
    c = 0;
    while (vr0 && c < 6000) begin @(negedge clk); c++; end
    chk("vo_raw_fall_x", int'(x0), 640);
`endif
    c = 0;
    while (vo0 && c < 6000) begin @(negedge clk); c++; end
    chk("vo_fall_x", int'(x0), 640 + PIPE);
    c = 0;
    while (hs0 && c < 6000) begin @(negedge clk); c++; end
    chk("hs_fall_n", n, (656 + PIPE) * 4 + 1);
    chk("hs_fall_x", int'(x0), 656 + PIPE);
    c = 0;
    while (!hs0 && c < 1000) begin @(negedge clk); c++; end
    chk("hs_low_clks", c, 384);
    c = 0;
    while (!fs1 && c < 2000) begin @(negedge clk); c++; end
    c = 0; v = 0; w = 0;
    do begin
      v += int'(vo1);
      w += int'(!vs1);
      @(negedge clk);
      c++;
    end while (!fs1 && c < 2000);
    chk("frame_clks", c, 576);
    chk("vo_clks", v, 144);
    chk("vs_low_clks", w, 96);
    do_reset(1);
    repeat (35 * 3 + 2) @(negedge clk);
    chk("mid_x", int'(x1), 3);
    chk("mid_y", int'(y1), 2);
    chk("mid_vo", int'(vo1), 1);
    do_reset(0);
    c = 0;
    while (hs1 && c < 200) begin @(negedge clk); c++; end
    chk("mid_hs_fall_n", n, (10 + PIPE) * 3 + 1);
    foreach (tbl[i]) begin
      off = $urandom_range(0, TD[tbl[i].s] - 1);
      do_reset($urandom_range(0, 3));
      repeat (tbl[i].k * TD[tbl[i].s] + 1 + off) @(negedge clk);
      chk($sformatf("tbl%0d_x", i), int'(tbl[i].s != 0 ? x1 : x0), tbl[i].x);
      chk($sformatf("tbl%0d_y", i), int'(tbl[i].s != 0 ? y1 : y0), tbl[i].y);
      chk($sformatf("tbl%0d_fs", i), int'(tbl[i].s != 0 ? fs1 : fs0), int'(tbl[i].fs != 0 && off == 0));
`ifdef VGA_SYNC_PIPE_ALIGN_EN
      chk($sformatf("tbl%0d_vo_raw", i), int'(tbl[i].s != 0 ? vr1 : vr0), tbl[i].vo);
`else
      chk($sformatf("tbl%0d_vo", i), int'(tbl[i].s != 0 ? vo1 : vo0), tbl[i].vo);
      chk($sformatf("tbl%0d_hs", i), int'(tbl[i].s != 0 ? hs1 : hs0), tbl[i].hs);
      chk($sformatf("tbl%0d_vs", i), int'(tbl[i].s != 0 ? vs1 : vs0), tbl[i].vs);
`endif
    end
    for (int r = 0; r < 12; r++) begin
      do_reset($urandom_range(0, 5));
      repeat ($urandom_range(1, 1500)) @(negedge clk);
    end
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
